// File: rtl/seq_detect_ctrl.sv
// Word serializer with an embedded overlapping Mealy "1001" detector and a per-word hit count.
// Optional macro DETECT_CARRY_EN keeps detector state across words so boundary-spanning patterns count.
module seq_detect_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       bit_out,
  output logic       hit,
  output logic       busy,
  output logic       done,
  output logic [3:0] match_cnt
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [1:0] {S0, S1, S2, S3} det_t;

  state_t     state, state_nx;
  det_t       det, det_nx;
  logic [2:0] idx;
  logic [7:0] data;
  logic [3:0] cnt;

  always_comb begin
    state_nx = state;
    det_nx   = det;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    bit_out  = 1'b0;
    hit      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nx = SHIFT;
`ifndef DETECT_CARRY_EN
          det_nx   = S0;
`endif
        end
      end
      SHIFT: begin
        busy    = 1'b1;
        bit_out = data[idx];
        case (det)
          S0:      det_nx = bit_out ? S1 : S0;
          S1:      det_nx = bit_out ? S1 : S2;
          S2:      det_nx = bit_out ? S1 : S3;
          S3: begin
            hit    = bit_out;
            det_nx = bit_out ? S1 : S0;
          end
          default: det_nx = S0;
        endcase
        if (idx == 3'd0) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      det       <= S0;
      idx       <= 3'd7;
      data      <= 8'd0;
      cnt       <= 4'd0;
      match_cnt <= 4'd0;
    end else begin
      state <= state_nx;
      det   <= det_nx;
      if (state == IDLE && in_valid) begin
        data <= in_data;
        idx  <= 3'd7;
        cnt  <= 4'd0;
      end else if (state == SHIFT) begin
        idx <= idx - 3'd1;
        cnt <= cnt + {3'b000, hit};
        // Include the final bit's hit so match_cnt is complete on entry to DONE.
        if (idx == 3'd0) match_cnt <= cnt + {3'b000, hit};
      end
    end
  end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed self-checking bench for seq_detect_ctrl: one task per scenario, hand-computed expectations.
module tb_seq_detect_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_ready, bit_out, hit, busy, done;
  logic [3:0] match_cnt;

  int total = 0;
  int bad   = 0;

  // Observations of one word transaction (recorded, compared by the calling test).
  logic [7:0] o_bits, o_hits, o_busy;
  logic       o_rdy_acc, o_rdy_shift, o_done, o_rdy_done, o_done_after, o_rdy_after, o_done_early;
  logic [3:0] o_mc, o_mc_after;

  seq_detect_ctrl dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .bit_out(bit_out), .hit(hit), .busy(busy), .done(done), .match_cnt(match_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one word from IDLE through DONE and back to IDLE (10 edges), recording outputs.
  // hold keeps in_valid high throughout; pulse_k>=0 pulses 0x12 during that SHIFT cycle.
  task automatic send_word(input logic [7:0] d, input bit hold, input int pulse_k);
    in_valid = 1'b1;
    in_data  = d;
    o_rdy_acc = in_ready;
    step();
    if (!hold) in_valid = 1'b0;
    o_rdy_shift = 1'b0;
    o_done_early = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k == pulse_k) begin
        in_valid = 1'b1;
        in_data  = 8'h12;
      end
      o_bits[7-k] = bit_out;
      o_hits[7-k] = hit;
      o_busy[7-k] = busy;
      o_rdy_shift = o_rdy_shift | in_ready;
      o_done_early = o_done_early | done;
      step();
      if (k == pulse_k && !hold) in_valid = 1'b0;
    end
    o_done     = done;
    o_mc       = match_cnt;
    o_rdy_done = in_ready;
    step();
    o_done_after = done;
    o_rdy_after  = in_ready;
    o_mc_after   = match_cnt;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b1;
    in_data = 8'hFF;
    step();
    step();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (hit !== 1'b0) begin bad++; $display("FAIL reset_hit got=%b exp=0", hit); end
    total++; if (bit_out !== 1'b0) begin bad++; $display("FAIL reset_bit_out got=%b exp=0", bit_out); end
    total++; if (match_cnt !== 4'd0) begin bad++; $display("FAIL reset_match_cnt got=%0d exp=0", match_cnt); end
    in_valid = 1'b0;
    reset = 1'b0;
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_basic_92();
    send_word(8'h92, 1'b0, -1);
    total++; if (o_rdy_acc !== 1'b1) begin bad++; $display("FAIL w92_ready_accept got=%b exp=1", o_rdy_acc); end
    total++; if (o_busy !== 8'hFF) begin bad++; $display("FAIL w92_busy got=%b exp=11111111", o_busy); end
    total++; if (o_bits !== 8'h92) begin bad++; $display("FAIL w92_bits got=%h exp=92", o_bits); end
    total++; if (o_hits !== 8'h12) begin bad++; $display("FAIL w92_hits got=%b exp=00010010", o_hits); end
    total++; if (o_rdy_shift !== 1'b0) begin bad++; $display("FAIL w92_ready_shift got=%b exp=0", o_rdy_shift); end
    total++; if (o_done_early !== 1'b0) begin bad++; $display("FAIL w92_done_early got=%b exp=0", o_done_early); end
    total++; if (o_done !== 1'b1) begin bad++; $display("FAIL w92_done_t9 got=%b exp=1", o_done); end
    total++; if (o_rdy_done !== 1'b0) begin bad++; $display("FAIL w92_ready_done got=%b exp=0", o_rdy_done); end
    total++; if (o_mc !== 4'd2) begin bad++; $display("FAIL w92_match_cnt got=%0d exp=2", o_mc); end
    total++; if (o_done_after !== 1'b0) begin bad++; $display("FAIL w92_done_pulse got=%b exp=0", o_done_after); end
    total++; if (o_rdy_after !== 1'b1) begin bad++; $display("FAIL w92_ready_after got=%b exp=1", o_rdy_after); end
    total++; if (o_mc_after !== 4'd2) begin bad++; $display("FAIL w92_match_hold got=%0d exp=2", o_mc_after); end
    total++; if (bit_out !== 1'b0 || hit !== 1'b0) begin bad++; $display("FAIL w92_idle_bit_hit got=%b%b exp=00", bit_out, hit); end
  endtask

  task automatic test_no_hit();
    send_word(8'h00, 1'b0, -1);
    total++; if (o_hits !== 8'h00) begin bad++; $display("FAIL w00_hits got=%b exp=00000000", o_hits); end
    total++; if (o_mc !== 4'd0) begin bad++; $display("FAIL w00_match_cnt got=%0d exp=0", o_mc); end
    send_word(8'hFF, 1'b0, -1);
    total++; if (o_bits !== 8'hFF) begin bad++; $display("FAIL wFF_bits got=%h exp=ff", o_bits); end
    total++; if (o_hits !== 8'h00) begin bad++; $display("FAIL wFF_hits got=%b exp=00000000", o_hits); end
    total++; if (o_mc !== 4'd0) begin bad++; $display("FAIL wFF_match_cnt got=%0d exp=0", o_mc); end
  endtask

  task automatic test_carry();
    logic [3:0] exp_mc;
    logic [7:0] exp_hits;
`ifdef DETECT_CARRY_EN
    exp_mc = 4'd1;
    exp_hits = 8'h80;
`else
    exp_mc = 4'd0;
    exp_hits = 8'h00;
`endif
    reset = 1'b1;
    step();
    reset = 1'b0;
    send_word(8'h04, 1'b0, -1);
    total++; if (o_mc !== 4'd0) begin bad++; $display("FAIL w04_match_cnt got=%0d exp=0", o_mc); end
    send_word(8'h80, 1'b0, -1);
    total++; if (o_hits !== exp_hits) begin bad++; $display("FAIL w80_hits got=%b exp=%b", o_hits, exp_hits); end
    total++; if (o_mc !== exp_mc) begin bad++; $display("FAIL w80_match_cnt got=%0d exp=%0d", o_mc, exp_mc); end
  endtask

  task automatic test_back_to_back();
    // 10011001 contains two overlapping-detector hits: bits 1-4 and bits 5-8.
    for (int w = 0; w < 3; w++) begin
      send_word(8'h99, 1'b1, -1);
      total++; if (o_rdy_acc !== 1'b1) begin bad++; $display("FAIL b2b_ready_accept w=%0d got=%b exp=1", w, o_rdy_acc); end
      total++; if (o_busy !== 8'hFF) begin bad++; $display("FAIL b2b_busy w=%0d got=%b exp=11111111", w, o_busy); end
      total++; if (o_rdy_shift !== 1'b0 || o_rdy_done !== 1'b0) begin bad++; $display("FAIL b2b_ready_low w=%0d got=%b%b exp=00", w, o_rdy_shift, o_rdy_done); end
      total++; if (o_hits !== 8'h11) begin bad++; $display("FAIL b2b_hits w=%0d got=%b exp=00010001", w, o_hits); end
      total++; if (o_mc !== 4'd2) begin bad++; $display("FAIL b2b_match_cnt w=%0d got=%0d exp=2", w, o_mc); end
    end
    in_valid = 1'b0;
    step();
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_stop_busy got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid_shift();
    in_valid = 1'b1;
    in_data = 8'h92;
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    total++; if (busy !== 1'b1 || hit !== 1'b1) begin bad++; $display("FAIL rst_mid_pre got busy=%b hit=%b exp 1 1", busy, hit); end
    reset = 1'b1;
    in_valid = 1'b1;
    step();
    total++; if (in_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL rst_mid_idle got ready=%b busy=%b exp 1 0", in_ready, busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_mid_done got=%b exp=0", done); end
    total++; if (match_cnt !== 4'd0) begin bad++; $display("FAIL rst_mid_match_cnt got=%0d exp=0", match_cnt); end
    in_valid = 1'b0;
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rst_mid_quiet k=%0d got done=%b busy=%b exp 0 0", k, done, busy); end
    end
  endtask

  task automatic test_ignore_valid();
    send_word(8'h92, 1'b0, 2);
    total++; if (o_bits !== 8'h92) begin bad++; $display("FAIL ign_bits got=%h exp=92", o_bits); end
    total++; if (o_mc !== 4'd2) begin bad++; $display("FAIL ign_match_cnt got=%0d exp=2", o_mc); end
    total++; if (o_done !== 1'b1) begin bad++; $display("FAIL ign_done got=%b exp=1", o_done); end
    step();
    total++; if (busy !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL ign_no_accept got busy=%b ready=%b exp 0 1", busy, in_ready); end
    total++; if (match_cnt !== 4'd2) begin bad++; $display("FAIL ign_match_hold got=%0d exp=2", match_cnt); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic_92();
    test_no_hit();
    test_carry();
    test_back_to_back();
    test_reset_mid_shift();
    test_ignore_valid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
